// File: rtl/arm_ctrl_pkg.sv
// arm_ctrl_pkg: shared flag indices, condition encodings and flag-write codes
package arm_ctrl_pkg;
   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;
   localparam logic [3:0] COND_EQ = 4'b0000;
   localparam logic [3:0] COND_NE = 4'b0001;
   localparam logic [3:0] COND_CS = 4'b0010;
   localparam logic [3:0] COND_CC = 4'b0011;
   localparam logic [3:0] COND_MI = 4'b0100;
   localparam logic [3:0] COND_PL = 4'b0101;
   localparam logic [3:0] COND_VS = 4'b0110;
   localparam logic [3:0] COND_VC = 4'b0111;
   localparam logic [3:0] COND_HI = 4'b1000;
   localparam logic [3:0] COND_LS = 4'b1001;
   localparam logic [3:0] COND_GE = 4'b1010;
   localparam logic [3:0] COND_LT = 4'b1011;
   localparam logic [3:0] COND_GT = 4'b1100;
   localparam logic [3:0] COND_LE = 4'b1101;
   localparam logic [3:0] COND_AL = 4'b1110;
   localparam logic [3:0] COND_NV = 4'b1111;
   localparam logic [1:0] FLAGW_NZ = 2'b10;
   localparam logic [1:0] FLAGW_CV = 2'b01;
endpackage

// File: rtl/condlogic_if.sv
// condlogic_if: strobe and flag bundle between the main FSM/decoder and condlogic
interface condlogic_if;
   logic [3:0] Cond;
   logic [3:0] ALUFlags;
   logic [1:0] FlagW;
   logic       PCS;
   logic       NextPC;
   logic       RegW;
   logic       MemW;
   logic       PCWrite;
   logic       RegWrite;
   logic       MemWrite;
   logic [3:0] Flags;
   modport master (
      output Cond, ALUFlags, FlagW, PCS, NextPC, RegW, MemW,
      input  PCWrite, RegWrite, MemWrite, Flags
   );
   modport slave (
      input  Cond, ALUFlags, FlagW, PCS, NextPC, RegW, MemW,
      output PCWrite, RegWrite, MemWrite, Flags
   );
endinterface

// File: rtl/condlogic_condcheck.sv
// condcheck: evaluates an ARM condition field against stored NZCV flags
module condcheck
   import arm_ctrl_pkg::*;
(
   input  logic [3:0] Cond,
   input  logic [3:0] Flags,
   output logic       CondEx
);
   logic n, z, c, v, ge;
   assign n  = Flags[FLAG_N];
   assign z  = Flags[FLAG_Z];
   assign c  = Flags[FLAG_C];
   assign v  = Flags[FLAG_V];
   assign ge = (n == v);
   // condition decode; the reserved code falls to the default and is masked by the wrapper
   always_comb begin
      case (Cond)
         COND_EQ: CondEx = z;
         COND_NE: CondEx = ~z;
         COND_CS: CondEx = c;
         COND_CC: CondEx = ~c;
         COND_MI: CondEx = n;
         COND_PL: CondEx = ~n;
         COND_VS: CondEx = v;
         COND_VC: CondEx = ~v;
         COND_HI: CondEx = c & ~z;
         COND_LS: CondEx = ~(c & ~z);
         COND_GE: CondEx = ge;
         COND_LT: CondEx = ~ge;
         COND_GT: CondEx = ~z & ge;
         COND_LE: CondEx = ~(~z & ge);
         COND_AL: CondEx = 1'b1;
         default: CondEx = 1'b0;
      endcase
   end
endmodule

// File: rtl/condlogic.sv
// condlogic: NZCV flag register and condition gating of the FSM write strobes
module condlogic
   import arm_ctrl_pkg::*;
(
   input logic        clk,
   input logic        reset,
   condlogic_if.slave bus
);
   logic [3:0] flags_q, flags_d;
   logic       cond_ex_delayed_q, cond_ex_delayed_d;
   logic       cond_raw, cond_ex;
   condcheck u_condcheck (
      .Cond   (bus.Cond),
      .Flags  (flags_q),
      .CondEx (cond_raw)
   );
   assign cond_ex = cond_raw & (bus.Cond != COND_NV);
   // next flag halves load independently when their write is requested and the condition passes
   always_comb begin
      flags_d[FLAG_N:FLAG_Z] = (bus.FlagW[1] & cond_ex) ? bus.ALUFlags[FLAG_N:FLAG_Z] : flags_q[FLAG_N:FLAG_Z];
      flags_d[FLAG_C:FLAG_V] = (bus.FlagW[0] & cond_ex) ? bus.ALUFlags[FLAG_C:FLAG_V] : flags_q[FLAG_C:FLAG_V];
      cond_ex_delayed_d      = cond_ex;
   end
   // state registers; reset wins over a flag write in the same cycle
   always_ff @(posedge clk) begin
      if (reset) begin
         flags_q           <= 4'b0000;
         cond_ex_delayed_q <= 1'b0;
      end else begin
         flags_q           <= flags_d;
         cond_ex_delayed_q <= cond_ex_delayed_d;
      end
   end
   assign bus.PCWrite  = (bus.PCS & cond_ex_delayed_q) | bus.NextPC;
   assign bus.RegWrite = bus.RegW & cond_ex_delayed_q;
   assign bus.MemWrite = bus.MemW & cond_ex_delayed_q;
   assign bus.Flags    = flags_q;
endmodule

// File: tb/tb_condlogic.sv
// tb_condlogic: scoreboard bench for condlogic against a behavioural flag/condition model
module tb_condlogic;
   logic clk = 1'b0;
   logic reset;
   condlogic_if bus ();
   condlogic dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;

   typedef struct packed {
      logic       pc;
      logic       rw;
      logic       mw;
      logic [3:0] fl;
   } exp_t;
   exp_t q[$];
   int   n_vec = 0;
   int   n_err = 0;

   bit   m_known = 0;
   bit   m_n, m_z, m_c, m_v, m_ced;

   // architectural meaning of a condition: pairs of codes share a predicate, odd code inverts it
   function automatic bit ref_cond(input logic [3:0] cc, input bit n, input bit z, input bit c, input bit v);
      bit base;
      int pair;
      pair = int'(cc) / 2;
      if (cc == 4'd15) return 1'b0;
      if (cc == 4'd14) return 1'b1;
      case (pair)
         0: base = z;
         1: base = c;
         2: base = n;
         3: base = v;
         4: base = c && !z;
         5: base = (n == v);
         default: base = !z && (n == v);
      endcase
      return (int'(cc) % 2 == 1) ? !base : base;
   endfunction

   task automatic apply(input bit rst, input logic [3:0] cc, input logic [3:0] af, input logic [1:0] fw,
                        input bit pcs, input bit npc, input bit rw, input bit mw);
      exp_t e;
      bit   cx;
      @(negedge clk);
      reset = rst; bus.Cond = cc; bus.ALUFlags = af; bus.FlagW = fw;
      bus.PCS = pcs; bus.NextPC = npc; bus.RegW = rw; bus.MemW = mw;
      if (m_known) begin
         e.pc = (pcs && m_ced) || npc;
         e.rw = rw && m_ced;
         e.mw = mw && m_ced;
         e.fl = {m_n, m_z, m_c, m_v};
         q.push_back(e);
      end
      if (rst) begin
         {m_n, m_z, m_c, m_v, m_ced} = 5'b0;
         m_known = 1;
      end else if (m_known) begin
         cx = ref_cond(cc, m_n, m_z, m_c, m_v);
         if (fw[1] && cx) {m_n, m_z} = af[3:2];
         if (fw[0] && cx) {m_c, m_v} = af[1:0];
         m_ced = cx;
      end
   endtask

   // monitor: every cycle with a pending expectation is compared mid-low-phase
   initial begin
      exp_t e, got;
      forever begin
         @(negedge clk);
         #2;
         if (q.size() > 0) begin
            e = q.pop_front();
            got = {bus.PCWrite, bus.RegWrite, bus.MemWrite, bus.Flags};
            n_vec++;
            if ($isunknown(got) || got !== e) begin
               n_err++;
               $display("FAIL strobes_flags @%0t: got pc=%b rw=%b mw=%b flags=%b, expected pc=%b rw=%b mw=%b flags=%b",
                        $time, got.pc, got.rw, got.mw, got.fl, e.pc, e.rw, e.mw, e.fl);
            end
         end
      end
   end

   initial begin
      reset = 1'b1; bus.Cond = 4'b1110; bus.ALUFlags = 4'b0; bus.FlagW = 2'b0;
      bus.PCS = 1'b0; bus.NextPC = 1'b0; bus.RegW = 1'b0; bus.MemW = 1'b0;
      apply(1, 4'b1110, 4'b1111, 2'b11, 0, 1, 1, 1);
      apply(1, 4'b1110, 4'b1111, 2'b11, 1, 0, 1, 1);
      apply(1, 4'b1110, 4'b1111, 2'b11, 0, 1, 1, 1);
      apply(0, 4'b1110, 4'b0100, 2'b11, 0, 0, 0, 0);
      apply(0, 4'b0000, 4'b0000, 2'b00, 0, 0, 1, 0);
      apply(0, 4'b0000, 4'b0000, 2'b00, 0, 0, 1, 0);
      apply(0, 4'b0001, 4'b1011, 2'b11, 1, 0, 1, 1);
      apply(0, 4'b0001, 4'b1011, 2'b11, 1, 0, 1, 1);
      apply(0, 4'b0001, 4'b1011, 2'b11, 1, 0, 1, 1);
      apply(1, 4'b1110, 4'b0000, 2'b00, 0, 0, 0, 0);
      apply(0, 4'b1110, 4'b1111, 2'b01, 0, 0, 0, 0);
      apply(0, 4'b1010, 4'b0000, 2'b00, 0, 0, 1, 1);
      apply(0, 4'b1010, 4'b0000, 2'b00, 0, 0, 1, 1);
      apply(0, 4'b0110, 4'b0000, 2'b00, 0, 0, 1, 1);
      apply(0, 4'b0110, 4'b0000, 2'b00, 1, 0, 1, 1);
      apply(0, 4'b1111, 4'b1111, 2'b11, 1, 1, 1, 1);
      apply(0, 4'b1111, 4'b1111, 2'b11, 1, 1, 1, 1);
      apply(0, 4'b1111, 4'b1111, 2'b11, 1, 0, 1, 1);
      apply(0, 4'b1110, 4'b0000, 2'b00, 0, 0, 1, 0);
      apply(0, 4'b1110, 4'b0000, 2'b00, 0, 0, 1, 0);
      apply(1, 4'b1110, 4'b1111, 2'b11, 0, 0, 1, 0);
      apply(0, 4'b1110, 4'b0000, 2'b00, 0, 0, 1, 0);
      for (int i = 0; i < 3000; i++) begin
         logic [3:0] cc;
         cc = 4'($urandom_range(0, 15));
         for (int k = 0; k < int'($urandom_range(1, 4)); k++)
            apply($urandom_range(0, 59) == 0, cc, 4'($urandom), 2'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom), 1'($urandom));
      end
      for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
      #3;
      if (q.size() > 0) begin
         n_err++;
         $display("FAIL drain: %0d expectations left, expected 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/condlogic.md
# condlogic

Conditional-execution stage of the multicycle ARM control unit. Holds the architectural NZCV flag register, evaluates the instruction's 4-bit condition field against the stored flags through `condcheck`, and gates the main FSM's write strobes (`PCWrite`, `RegWrite`, `MemWrite`) and its own flag updates with the result. Sits between the main FSM/decoder (strobes in) and the datapath enables (strobes out).

## Interface
Parameters: none.

Ports (name, direction, width, meaning):
- `clk` input 1: system clock, rising edge.
- `reset` input 1: synchronous, active-high reset.
- `Cond` input 4: condition field, `Instr[31:28]`, held stable for the whole instruction.
- `ALUFlags` input 4: `{N,Z,C,V}` from the ALU in the current cycle.
- `FlagW` input 2: flag-write request from the decoder.
  - bit 1 = update N,Z.
  - bit 0 = update C,V.
- `PCS` input 1: the instruction writes the PC (branch or Rd = R15).
- `NextPC` input 1: unconditional PC update (fetch state).
- `RegW` input 1: register-file write request from the FSM.
- `MemW` input 1: memory write request from the FSM.
- `PCWrite` output 1: gated PC enable.
- `RegWrite` output 1: gated register-file enable.
- `MemWrite` output 1: gated memory write enable.
- `Flags` output 4: current stored `{N,Z,C,V}`, for debug and verification.

## Operation
- **Flag register:** two independent 2-bit registers.
  - `Flags[3:2]` (N,Z) loads `ALUFlags[3:2]` on a rising edge when `FlagW[1] & CondEx`.
  - `Flags[1:0]` (C,V) loads `ALUFlags[1:0]` on a rising edge when `FlagW[0] & CondEx`.
  - Otherwise each half holds its value.
- **CondEx:** combinational from `Cond` and the stored `Flags` (never from `ALUFlags`).
  - `Cond` 0000–1101 uses the standard ARM encodings: EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE.
  - GE means N == V.
  - HI means C & ~Z.
  - GT means ~Z & GE.
  - 1110 (AL) gives 1.
  - 1111 is reserved. `condlogic` forces `CondEx` = 0 for it, so the reserved encoding never produces X on the strobes.
- **CondExDelayed:** 1-bit register loaded with `CondEx` on every rising edge.
- **Output gating (combinational):**
  - `PCWrite` = `(PCS & CondExDelayed) | NextPC`
  - `RegWrite` = `RegW & CondExDelayed`
  - `MemWrite` = `MemW & CondExDelayed`
- **Flag write versus CondEx:** a flag write uses the undelayed `CondEx`. The flags written by an instruction therefore affect `CondEx` from the next cycle on, and the instruction's own strobes from two cycles on. Because `Cond` is constant across an instruction and flags are written only in its ALU writeback state, a failed condition suppresses all of the instruction's side effects.
- **Simultaneous events:**
  - `FlagW` = 11 with `CondEx` = 1 updates all four flags in the same edge.
  - `NextPC` overrides a failed condition; fetch always advances.

## Timing
- **Reset** (synchronous; `reset` = 1 at the edge):
  - `Flags` = 0000 and `CondExDelayed` = 0.
  - As a result, after that edge `PCWrite` = `NextPC`, `RegWrite` = 0, `MemWrite` = 0.
- **Reset priority:** reset takes priority over any flag write in the same cycle. Reset asserted mid-instruction discards the pending `CondExDelayed`.
- **Latency:**
  - Flag load: 1 edge.
  - `Cond` change to `CondEx`: 0 cycles.
  - `CondEx` to the gated strobes: 1 cycle.
- **Outputs:** no outputs are registered except `Flags`. The strobes are combinational from the registered `CondExDelayed` and the FSM inputs.
- **Handshake:** none. The FSM must hold `Cond` stable from the decode state through writeback.

## Structure
- Shared package `arm_ctrl_pkg`:
  - `FLAG_N`=3, `FLAG_Z`=2, `FLAG_C`=1, `FLAG_V`=0.
  - Condition encodings `COND_EQ` … `COND_AL` and `COND_NV` = 4'b1111.
  - `FLAGW_NZ`=2'b10, `FLAGW_CV`=2'b01.
- Sub-module: `condcheck` (`Cond`, `Flags` → `CondEx`), instantiated once. `condlogic` wraps it with the reserved-code override.
- Registers `Flags` and `CondExDelayed` are inferred locally. No other hierarchy.

## Test plan
1. **Reset:** hold `reset` for 2 edges with `FlagW` = 11, `ALUFlags` = 1111 → `Flags` = 0000; `RegWrite` = `MemWrite` = 0; `PCWrite` follows `NextPC`.
2. **EQ, condition taken:** `Cond` = 1110, `FlagW` = 11, `ALUFlags` = 0100, 1 edge → `Flags` = 0100. Then `Cond` = 0000, `RegW` = 1 → `RegWrite` = 1 one cycle after `Cond` is applied.
3. **NE, condition fails:** with `Flags` = 0100, `Cond` = 0001, `RegW` = `MemW` = `PCS` = 1, `FlagW` = 11, `ALUFlags` = 1011 → all strobes stay 0 and `Flags` stays 0100.
4. **Partial write:** `Cond` = 1110, `FlagW` = 01, `ALUFlags` = 1111 from `Flags` = 0000 → `Flags` = 0011. Then GE (1010) → `CondEx` = 0; VS (0110) → 1.
5. **Reserved code:** `Cond` = 1111, `NextPC` = 1, `PCS` = 1 → `PCWrite` = 1 (via `NextPC`), `RegWrite` = `MemWrite` = 0, no X on any output. With `NextPC` = 0 → `PCWrite` = 0.
6. **Reset mid-instruction:** `CondExDelayed` = 1 with `RegW` = 1, assert `reset` for 1 edge → `RegWrite` = 0 in the following cycle and `Flags` = 0000.
